// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run sequencer for the 9-bit-instruction core.
// Turns a host start edge into a held core reset, then a run window that ends
// on a HALT_PC match (done) or on the watchdog (done + timeout).
// Optional build macro: CORE_RUN_CTRL_HALT_ON_LOOP_EN -- also ends a run when
// the program counter jumps to itself.
module core_run_ctrl #(
   parameter int unsigned D       = 12,
   parameter int unsigned HALT_PC = 128,
   parameter int unsigned WD      = 16,
   parameter int unsigned RST_CYC = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [D-1:0]  prog_ctr,
   input  logic [WD-1:0] wd_limit,
   output logic          core_reset,
   output logic          core_en,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [WD-1:0] cycle_cnt
);

   localparam int unsigned RCW = 4;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CRST = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_TOUT = 3'd4;

   localparam logic [D-1:0]   HALT_VAL = D'(HALT_PC);
   localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYC - 1);

   logic [2:0]    state_q, state_d;
   logic          req_q;
   logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
   logic [WD-1:0] cycle_cnt_q, cycle_cnt_d;
   logic          core_reset_q, core_reset_d;
   logic          core_en_q, core_en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;

   logic          start;
   logic          halt_hit;
   logic          wd_hit;
   logic [WD:0]   cnt_plus1;

`ifdef CORE_RUN_CTRL_HALT_ON_LOOP_EN
   logic [D-1:0]  last_pc_q, last_pc_d;
   logic          loop_valid_q, loop_valid_d;

   // A jump-to-self after the first RUN cycle counts as program completion.
   always_comb begin
      halt_hit     = (prog_ctr == HALT_VAL) || (loop_valid_q && (prog_ctr == last_pc_q));
      last_pc_d    = last_pc_q;
      loop_valid_d = loop_valid_q;
      if (state_q == S_RUN) begin
         last_pc_d    = prog_ctr;
         loop_valid_d = 1'b1;
      end else if (state_d == S_RUN) begin
         loop_valid_d = 1'b0;
      end
   end

   // Loop-detect history registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_pc_q    <= '0;
         loop_valid_q <= 1'b0;
      end else begin
         last_pc_q    <= last_pc_d;
         loop_valid_q <= loop_valid_d;
      end
   end
`else
   // Only the HALT_PC match ends a run normally.
   always_comb begin
      halt_hit = (prog_ctr == HALT_VAL);
   end
`endif

   // Next-state, counters and state-decoded outputs (registered from state_d).
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      start       = req & ~req_q;
      cnt_plus1   = {1'b0, cycle_cnt_q} + (WD+1)'(1);
      wd_hit      = (wd_limit != '0) && (cnt_plus1 >= {1'b0, wd_limit});

      case (state_q)
         S_IDLE, S_DONE, S_TOUT: begin
            if (start) begin
               state_d     = S_CRST;
               rst_cnt_d   = RST_LOAD;
               cycle_cnt_d = '0;
            end
         end
         S_CRST: begin
            if (rst_cnt_q == '0) begin
               state_d = S_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q - RCW'(1);
            end
         end
         S_RUN: begin
            if (cycle_cnt_q != '1) begin
               cycle_cnt_d = cycle_cnt_q + WD'(1);
            end
            if (halt_hit) begin
               state_d = S_DONE;
            end else if (wd_hit) begin
               state_d = S_TOUT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      core_reset_d = (state_d == S_IDLE) || (state_d == S_CRST);
      core_en_d    = (state_d == S_RUN);
      busy_d       = (state_d == S_CRST) || (state_d == S_RUN);
      done_d       = (state_d == S_DONE) || (state_d == S_TOUT);
      timeout_d    = (state_d == S_TOUT);
   end

   // State, start-edge history and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         req_q        <= 1'b0;
         rst_cnt_q    <= '0;
         cycle_cnt_q  <= '0;
         core_reset_q <= 1'b1;
         core_en_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req;
         rst_cnt_q    <= rst_cnt_d;
         cycle_cnt_q  <= cycle_cnt_d;
         core_reset_q <= core_reset_d;
         core_en_q    <= core_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
      end
   end

   assign core_reset = core_reset_q;
   assign core_en    = core_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed and random runs; expected run endings are
// queued by the stimulus and checked by a monitor when done rises.
module tb_core_run_ctrl;

   localparam int unsigned D       = 12;
   localparam int unsigned WD      = 16;
   localparam int unsigned HALT    = 128;
   localparam int unsigned RST_CYC = 2;
`ifdef CORE_RUN_CTRL_HALT_ON_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          req;
   logic [D-1:0]  prog_ctr;
   logic [WD-1:0] wd_limit;
   logic          core_reset;
   logic          core_en;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [WD-1:0] cycle_cnt;

   typedef struct {
      int cnt;
      bit tout;
   } exp_t;

   exp_t          exp_q[$];
   logic [D-1:0]  pcs_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;

   core_run_ctrl #(.D(D), .HALT_PC(HALT), .WD(WD), .RST_CYC(RST_CYC)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .prog_ctr   (prog_ctr),
      .wd_limit   (wd_limit),
      .core_reset (core_reset),
      .core_en    (core_en),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .cycle_cnt  (cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: walk the per-cycle PC list; first halt (or self-loop) wins,
   // otherwise the run ends once the run-cycle count reaches the limit.
   function automatic void model(input int wd, output int cnt, output bit tout);
      cnt  = -1;
      tout = 1'b0;
      for (int i = 0; i < pcs_q.size(); i++) begin
         bit halt;
         halt = (int'(pcs_q[i]) == HALT);
         if (LOOP_EN && i > 0 && pcs_q[i] == pcs_q[i-1]) halt = 1'b1;
         if (halt) begin
            cnt = i + 1;
            return;
         end
         if (wd != 0 && i + 1 >= wd) begin
            cnt  = i + 1;
            tout = 1'b1;
            return;
         end
      end
   endfunction

   // One complete run: start edge, reset window, then feed pcs_q per RUN cycle.
   task automatic do_run(input int wd, input string tag);
      int   cnt;
      bit   tout;
      int   n;
      int   guard;
      exp_t e;
      model(wd, cnt, tout);
      e.cnt  = cnt;
      e.tout = tout;
      exp_q.push_back(e);
      wd_limit = 16'(wd);
      prog_ctr = '0;
      req = 1'b0;
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      check({tag, " start flags"}, {60'd0, done, busy, core_reset, (cycle_cnt == '0)}, 64'b0111);
      n = 0;
      guard = 0;
      while (!core_en && guard < 50) begin
         if (core_reset && busy) n++;
         guard++;
         @(negedge clk);
      end
      check({tag, " reset window"}, 64'(n), 64'(RST_CYC));
      n = 0;
      while (core_en && n < 3000) begin
         prog_ctr = pcs_q[(n < pcs_q.size()) ? n : pcs_q.size() - 1];
         n++;
         @(negedge clk);
      end
      check({tag, " run length"}, 64'(n), 64'(cnt));
   endtask

   // Monitor: each rising done retires one queued expectation.
   initial begin
      logic done_prev;
      exp_t e;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected done", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("end timeout", {63'd0, timeout}, {63'd0, e.tout});
               check("end cycle_cnt", 64'(cycle_cnt), 64'(e.cnt));
               check("end idle flags", {61'd0, busy, core_en, core_reset}, 64'd0);
            end
         end
         done_prev = done;
      end
   end

   initial begin
      int bad;
      int wd;
      int len;
      int guard;
      reset    = 1'b0;
      req      = 1'b0;
      prog_ctr = '0;
      wd_limit = '0;
      #2 reset = 1'b1;
      #1;
      check("reset flags", {59'd0, core_reset, core_en, busy, done, timeout}, 64'b10000);
      check("reset cycle_cnt", 64'(cycle_cnt), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Normal run to HALT_PC.
      pcs_q.delete();
      for (int i = 0; i <= 128; i++) pcs_q.push_back(D'(i));
      do_run(0, "t1");

      // Watchdog with PC stuck.
      pcs_q.delete();
      repeat (60) pcs_q.push_back(D'(5));
      do_run(50, "t2");

      // Halt coinciding with the watchdog limit.
      pcs_q.delete();
      for (int i = 0; i < 9; i++) pcs_q.push_back(D'(i));
      pcs_q.push_back(D'(HALT));
      do_run(10, "t3");

      // Held req must not restart.
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!done || busy || core_en || timeout) bad++;
      end
      check("t4 held req", 64'(bad), 64'd0);

      // Fresh edge restarts.
      pcs_q.delete();
      pcs_q.push_back(D'(7));
      pcs_q.push_back(D'(3));
      pcs_q.push_back(D'(HALT));
      do_run(0, "t4");

      // Self-loop program.
      pcs_q.delete();
      pcs_q.push_back(D'(0));
      pcs_q.push_back(D'(1));
      pcs_q.push_back(D'(2));
      pcs_q.push_back(D'(2));
      pcs_q.push_back(D'(3));
      pcs_q.push_back(D'(HALT));
      do_run(0, "t6");

      // Asynchronous reset mid-run.
      wd_limit = '0;
      prog_ctr = D'(1);
      req = 1'b0;
      @(negedge clk);
      req = 1'b1;
      guard = 0;
      while (!core_en && guard < 50) begin
         guard++;
         @(negedge clk);
      end
      check("t5 reached run", {63'd0, core_en}, 64'd1);
      for (int i = 0; i < 19; i++) begin
         prog_ctr = D'(i + 1);
         @(negedge clk);
      end
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("t5 async flags", {59'd0, core_reset, core_en, busy, done, timeout}, 64'b10000);
      check("t5 async cycle_cnt", 64'(cycle_cnt), 64'd0);
      req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy || !core_reset || core_en) bad++;
      end
      check("t5 no restart", 64'(bad), 64'd0);

      // Random runs.
      for (int r = 0; r < 12; r++) begin
         pcs_q.delete();
         len = int'($urandom_range(1, 40));
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) == 0) pcs_q.push_back(D'(HALT));
            else pcs_q.push_back(D'($urandom_range(0, 15)));
         end
         pcs_q.push_back(D'(HALT));
         wd = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 45));
         do_run(wd, "rand");
      end

      repeat (3) @(negedge clk);
      check("queue drained", 64'(exp_q.size()), 64'd0);

      // req already high when reset releases starts a run on the first edge.
      reset = 1'b1;
      req   = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("req at release", {62'd0, busy, core_reset}, 64'b11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time limit.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
